// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Parity support is selected at build time with UART_TX_PARITY_EN.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic logic calc_parity(
    input logic [UART_DATA_BITS-1:0] d,
    input logic                      odd
  );
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter for the UART transmitter.
// bit_done marks the final clk cycle of each bit period.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic resetn,
  input  logic restart,
  output logic bit_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_done = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: holding register + shifter, 8N1 framing on TXD.
// Define UART_TX_PARITY_EN to add a parity bit after the data bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       TXD,
  output logic       busy
);

  localparam bit CFG_OK = (CLKS_PER_BIT >= 2)
                       && (STOP_BITS == 1 || STOP_BITS == 2)
                       && (PARITY_ODD == 0 || PARITY_ODD == 1);

  if (!CFG_OK) begin : g_cfg_check
    $error("uart_tx: illegal parameter set");
  end

  tx_state_t  state_q, state_n;
  logic [7:0] shift_q, shift_n;
  logic [7:0] hold_q, hold_n;
  logic       hold_full_q, hold_full_n;
  logic [2:0] idx_q, idx_n;
  logic       stop_q, stop_n;
  logic       txd_q, txd_n;
  logic       ready_q, busy_q;
  logic       accept, bit_done, restart, last_stop;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .resetn  (resetn),
    .restart (restart),
    .bit_done(bit_done)
  );

  assign accept    = tx_valid && ready_q;
  assign last_stop = (state_q == STOP) && bit_done
                  && ((STOP_BITS == 1) || stop_q);
  assign restart   = (state_q == IDLE) || (state_n != state_q);

  always_comb begin
    state_n     = state_q;
    shift_n     = shift_q;
    hold_n      = hold_q;
    hold_full_n = hold_full_q;
    idx_n       = idx_q;
    stop_n      = stop_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shift_n = tx_data;
          state_n = START;
        end
      end
      START: begin
        if (bit_done) begin
          state_n = DATA;
          idx_n   = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
            stop_n = 1'b0;
          end else begin
            idx_n = idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (last_stop) begin
          if (hold_full_q) begin
            shift_n     = hold_q;
            hold_full_n = 1'b0;
            state_n     = START;
          end else if (accept) begin
            shift_n = tx_data;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else if (bit_done) begin
          stop_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // A byte arriving mid-frame parks in the holding register.
    if (accept && state_q != IDLE && !last_stop) begin
      hold_n      = tx_data;
      hold_full_n = 1'b1;
    end
  end

  always_comb begin
    txd_n = UART_IDLE_LEVEL;
    unique case (state_n)
      IDLE:  txd_n = UART_IDLE_LEVEL;
      START: txd_n = 1'b0;
      DATA:  txd_n = shift_n[idx_n];
`ifdef UART_TX_PARITY_EN
      PARITY: txd_n = calc_parity(shift_n, 1'(PARITY_ODD));
`endif
      STOP:  txd_n = 1'b1;
      default: txd_n = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      idx_q       <= '0;
      stop_q      <= 1'b0;
      txd_q       <= UART_IDLE_LEVEL;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      shift_q     <= shift_n;
      hold_q      <= hold_n;
      hold_full_q <= hold_full_n;
      idx_q       <= idx_n;
      stop_q      <= stop_n;
      txd_q       <= txd_n;
      ready_q     <= !hold_full_n;
      busy_q      <= (state_n != IDLE) || hold_full_n;
    end
  end

  assign TXD      = txd_q;
  assign tx_ready = ready_q;
  assign busy     = busy_q;

endmodule
